// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
// State encoding is exported on the debug port, so the values are fixed.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VEND    = 3'd2,
    CHANGE  = 3'd3
  } vendState_t;

  localparam logic [6:0] NICKEL  = 7'd5;
  localparam logic [6:0] DIME    = 7'd10;
  localparam logic [6:0] QUARTER = 7'd25;

  localparam int unsigned DEFAULT_PRICE = 40;
  localparam int          TIMER_W       = 32;

  // Largest coin that does not exceed the credit still owed.
  function automatic logic [6:0] greedyCoin(input logic [6:0] credit);
    if (credit >= QUARTER) return QUARTER;
    if (credit >= DIME)    return DIME;
    return NICKEL;
  endfunction

endpackage

// File: rtl/vend_if.sv
// Coin/cancel inputs and display/LED outputs of the vending controller.
// master = debounce/driver side, slave = the sequencer.
interface vend_if;
  import vend_pkg::*;

  logic        nickelPulse;
  logic        dimePulse;
  logic        quarterPulse;
  logic        cancelPulse;
  logic [6:0]  creditCents;
  logic        dispenseActive;
  logic        changeNickel;
  logic        changeDime;
  logic        changeQuarter;
  logic        coinReject;
  logic        busy;
  logic [15:0] vendCount;
  logic [2:0]  state;

  modport master (
    output nickelPulse, dimePulse, quarterPulse, cancelPulse,
    input  creditCents, dispenseActive, changeNickel, changeDime, changeQuarter,
           coinReject, busy, vendCount, state
  );

  modport slave (
    input  nickelPulse, dimePulse, quarterPulse, cancelPulse,
    output creditCents, dispenseActive, changeNickel, changeDime, changeQuarter,
           coinReject, busy, vendCount, state
  );

endinterface

// File: rtl/vend_timer.sv
// Load/expire down-counter shared by the dispense, change-interval and
// timeout phases; expired is the terminal-count compare against zero.
module vend_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: accumulates credit from debounced coin
// pulses, times the dispense phase and pays change/refunds coin by coin.
//
// state   | meaning
// IDLE    | no credit; first accepted coin starts a transaction
// COLLECT | accumulating credit; cancel or inactivity timeout refunds
// VEND    | dispenseActive held for DISPENSE_CYCLES, then price deducted
// CHANGE  | greedy change strobes every CHANGE_CYCLES until credit is 0
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned PRICE           = DEFAULT_PRICE,
  parameter int unsigned DISPENSE_CYCLES = 50_000_000,
  parameter int unsigned CHANGE_CYCLES   = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 1_500_000_000
) (
  input logic   clk,
  input logic   reset,
  vend_if.slave bus
);

  localparam logic [6:0]         PRICE_C       = 7'(PRICE);
  localparam logic [TIMER_W-1:0] DISPENSE_LOAD = TIMER_W'(DISPENSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CHANGE_LOAD   = TIMER_W'(CHANGE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);

  vendState_t  stateQ, stateD;
  logic [6:0]  creditQ, creditD;
  logic [15:0] vendCountQ, vendCountD;
  logic        rejectQ, rejectD;
  logic        dispenseQ, dispenseD;
  logic        busyQ, busyD;
  logic        chgNickelQ, chgNickelD;
  logic        chgDimeQ, chgDimeD;
  logic        chgQuarterQ, chgQuarterD;

  logic               tmrLoad, tmrDec, tmrExpired;
  logic [TIMER_W-1:0] tmrLoadValue, tmrCount;

  logic       coinAny, coinHit, coinExtra;
  logic [6:0] coinValue, creditSum, payCoin;

  vend_timer #(.W(TIMER_W)) uTimer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmrLoad),
    .loadValue (tmrLoadValue),
    .dec       (tmrDec),
    .count     (tmrCount),
    .expired   (tmrExpired)
  );

  // Nickel > dime > quarter; coinExtra flags a second pulse that must be rejected.
  always_comb begin
    coinHit   = 1'b0;
    coinExtra = 1'b0;
    coinValue = '0;
    coinAny   = bus.nickelPulse | bus.dimePulse | bus.quarterPulse;
    if (bus.nickelPulse) begin
      coinHit   = 1'b1;
      coinValue = NICKEL;
      coinExtra = bus.dimePulse | bus.quarterPulse;
    end else if (bus.dimePulse) begin
      coinHit   = 1'b1;
      coinValue = DIME;
      coinExtra = bus.quarterPulse;
    end else if (bus.quarterPulse) begin
      coinHit   = 1'b1;
      coinValue = QUARTER;
    end
    creditSum = creditQ + coinValue;
    payCoin   = greedyCoin(creditQ);
  end

  always_comb begin
    stateD       = stateQ;
    creditD      = creditQ;
    vendCountD   = vendCountQ;
    rejectD      = 1'b0;
    chgNickelD   = 1'b0;
    chgDimeD     = 1'b0;
    chgQuarterD  = 1'b0;
    tmrLoad      = 1'b0;
    tmrLoadValue = '0;
    tmrDec       = 1'b0;

    case (stateQ)
      IDLE: begin
        creditD = '0;
        if (coinHit) begin
          creditD = coinValue;
          rejectD = coinExtra;
          tmrLoad = 1'b1;
          if (coinValue >= PRICE_C) begin
            stateD       = VEND;
            tmrLoadValue = DISPENSE_LOAD;
          end else begin
            stateD       = COLLECT;
            tmrLoadValue = TIMEOUT_LOAD;
          end
        end
      end

      COLLECT: begin
        if (bus.cancelPulse) begin
          rejectD = coinAny;
          stateD  = CHANGE;
          tmrLoad = 1'b1;
        end else if (coinHit) begin
          creditD = creditSum;
          rejectD = coinExtra;
          tmrLoad = 1'b1;
          if (creditSum >= PRICE_C) begin
            stateD       = VEND;
            tmrLoadValue = DISPENSE_LOAD;
          end else begin
            tmrLoadValue = TIMEOUT_LOAD;
          end
        end else if (tmrExpired) begin
          stateD  = CHANGE;
          tmrLoad = 1'b1;
        end else begin
          tmrDec = 1'b1;
        end
      end

      VEND: begin
        rejectD = coinAny;
        if (tmrExpired) begin
          creditD = creditQ - PRICE_C;
          if (vendCountQ != 16'hFFFF) vendCountD = vendCountQ + 16'd1;
          if (creditQ == PRICE_C) begin
            stateD = IDLE;
          end else begin
            stateD  = CHANGE;
            tmrLoad = 1'b1;
          end
        end else begin
          tmrDec = 1'b1;
        end
      end

      CHANGE: begin
        rejectD = coinAny;
        if (creditQ == '0) begin
          stateD = IDLE;
        end else if (tmrExpired) begin
          creditD     = creditQ - payCoin;
          chgQuarterD = (payCoin == QUARTER);
          chgDimeD    = (payCoin == DIME);
          chgNickelD  = (payCoin == NICKEL);
          if (creditQ == payCoin) begin
            stateD = IDLE;
          end else begin
            tmrLoad      = 1'b1;
            tmrLoadValue = CHANGE_LOAD;
          end
        end else begin
          tmrDec = 1'b1;
        end
      end

      default: begin
        stateD  = IDLE;
        creditD = '0;
      end
    endcase

    dispenseD = (stateD == VEND);
    busyD     = (stateD == VEND) || (stateD == CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ      <= IDLE;
      creditQ     <= '0;
      vendCountQ  <= '0;
      rejectQ     <= 1'b0;
      dispenseQ   <= 1'b0;
      busyQ       <= 1'b0;
      chgNickelQ  <= 1'b0;
      chgDimeQ    <= 1'b0;
      chgQuarterQ <= 1'b0;
    end else begin
      stateQ      <= stateD;
      creditQ     <= creditD;
      vendCountQ  <= vendCountD;
      rejectQ     <= rejectD;
      dispenseQ   <= dispenseD;
      busyQ       <= busyD;
      chgNickelQ  <= chgNickelD;
      chgDimeQ    <= chgDimeD;
      chgQuarterQ <= chgQuarterD;
    end
  end

  assign bus.state          = stateQ;
  assign bus.creditCents    = creditQ;
  assign bus.vendCount      = vendCountQ;
  assign bus.coinReject     = rejectQ;
  assign bus.dispenseActive = dispenseQ;
  assign bus.busy           = busyQ;
  assign bus.changeNickel   = chgNickelQ;
  assign bus.changeDime     = chgDimeQ;
  assign bus.changeQuarter  = chgQuarterQ;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with short timer parameters.
// Packed view: {credit[7], state[3], dispense, chgQ, chgD, chgN, reject, busy, vendCount[16]}.
module tb_vend_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vend_if bus();

  vend_sequencer #(
    .PRICE           (40),
    .DISPENSE_CYCLES (4),
    .CHANGE_CYCLES   (3),
    .TIMEOUT_CYCLES  (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  in;     // {nickel, dime, quarter, cancel}
    logic [6:0]  credit;
    logic [2:0]  st;
    logic        disp;
    logic [2:0]  chg;    // {quarter, dime, nickel}
    logic        rej;
    logic        busy;
    logic [15:0] vc;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t vecs[23];

  function automatic vec_t v(logic [3:0] in, logic [6:0] cr, logic [2:0] st, logic disp,
                             logic [2:0] chg, logic rej, logic busy, logic [15:0] vc);
    vec_t r;
    r.in = in; r.credit = cr; r.st = st; r.disp = disp;
    r.chg = chg; r.rej = rej; r.busy = busy; r.vc = vc;
    return r;
  endfunction

  function automatic logic [31:0] packExp(vec_t r);
    return {r.credit, r.st, r.disp, r.chg, r.rej, r.busy, r.vc};
  endfunction

  function automatic logic [31:0] packAct();
    return {bus.creditCents, bus.state, bus.dispenseActive, bus.changeQuarter,
            bus.changeDime, bus.changeNickel, bus.coinReject, bus.busy, bus.vendCount};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] in);
    bus.nickelPulse  = in[3];
    bus.dimePulse    = in[2];
    bus.quarterPulse = in[1];
    bus.cancelPulse  = in[0];
  endtask

  task automatic step(logic [3:0] in);
    drive(in);
    @(posedge clk);
    #1;
    drive(4'b0000);
  endtask

  task automatic doReset(string name);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(name, packAct(), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] strobeSeen;
    drive(4'b0000);

    vecs[0]  = v(4'b0010, 25, 1, 0, 3'b000, 0, 0, 0);
    vecs[1]  = v(4'b0010, 50, 2, 1, 3'b000, 0, 1, 0);
    vecs[2]  = v(4'b0000, 50, 2, 1, 3'b000, 0, 1, 0);
    vecs[3]  = v(4'b0010, 50, 2, 1, 3'b000, 1, 1, 0);
    vecs[4]  = v(4'b0000, 50, 2, 1, 3'b000, 0, 1, 0);
    vecs[5]  = v(4'b0000, 10, 3, 0, 3'b000, 0, 1, 1);
    vecs[6]  = v(4'b0000,  0, 0, 0, 3'b010, 0, 0, 1);
    vecs[7]  = v(4'b0000,  0, 0, 0, 3'b000, 0, 0, 1);
    vecs[8]  = v(4'b0100, 10, 1, 0, 3'b000, 0, 0, 1);
    vecs[9]  = v(4'b0100, 20, 1, 0, 3'b000, 0, 0, 1);
    vecs[10] = v(4'b0100, 30, 1, 0, 3'b000, 0, 0, 1);
    vecs[11] = v(4'b0100, 40, 2, 1, 3'b000, 0, 1, 1);
    vecs[12] = v(4'b0000, 40, 2, 1, 3'b000, 0, 1, 1);
    vecs[13] = v(4'b0000, 40, 2, 1, 3'b000, 0, 1, 1);
    vecs[14] = v(4'b0000, 40, 2, 1, 3'b000, 0, 1, 1);
    vecs[15] = v(4'b0000,  0, 0, 0, 3'b000, 0, 0, 2);
    vecs[16] = v(4'b0000,  0, 0, 0, 3'b000, 0, 0, 2);
    vecs[17] = v(4'b1100,  5, 1, 0, 3'b000, 1, 0, 2);
    vecs[18] = v(4'b0000,  5, 1, 0, 3'b000, 0, 0, 2);
    vecs[19] = v(4'b0011,  5, 3, 0, 3'b000, 1, 1, 2);
    vecs[20] = v(4'b0000,  0, 0, 0, 3'b001, 0, 0, 2);
    vecs[21] = v(4'b0001,  0, 0, 0, 3'b000, 0, 0, 2);
    vecs[22] = v(4'b1010,  5, 1, 0, 3'b000, 1, 0, 2);

    doReset("reset_state");

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), packAct(), packExp(vecs[i]));
    end

    // Quarter + dime then cancel: quarter strobe, dime strobe 3 cycles later.
    doReset("reset_a");
    step(4'b0010);
    step(4'b0100);
    step(4'b0001);
    check("cancel_enter", packAct(), {7'd35, 3'd3, 1'b0, 3'b000, 1'b0, 1'b1, 16'd0});
    step(4'b0000);
    check("refund_quarter", packAct(), {7'd10, 3'd3, 1'b0, 3'b100, 1'b0, 1'b1, 16'd0});
    step(4'b0000);
    check("refund_gap1", packAct(), {7'd10, 3'd3, 1'b0, 3'b000, 1'b0, 1'b1, 16'd0});
    step(4'b0000);
    check("refund_gap2", packAct(), {7'd10, 3'd3, 1'b0, 3'b000, 1'b0, 1'b1, 16'd0});
    step(4'b0000);
    check("refund_dime", packAct(), {7'd0, 3'd0, 1'b0, 3'b010, 1'b0, 1'b0, 16'd0});

    // Nickel then inactivity: 20 cycles in COLLECT before the refund.
    doReset("reset_b");
    step(4'b1000);
    for (int i = 0; i < 19; i++) step(4'b0000);
    check("timeout_not_yet", packAct(), {7'd5, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 16'd0});
    step(4'b0000);
    check("timeout_fire", packAct(), {7'd5, 3'd3, 1'b0, 3'b000, 1'b0, 1'b1, 16'd0});
    step(4'b0000);
    check("timeout_nickel", packAct(), {7'd0, 3'd0, 1'b0, 3'b001, 1'b0, 1'b0, 16'd0});

    // 60 cents vends with 20 remaining; async reset mid-CHANGE discards it.
    doReset("reset_c");
    step(4'b0010);
    step(4'b0100);
    step(4'b0010);
    check("vend60_enter", packAct(), {7'd60, 3'd2, 1'b1, 3'b000, 1'b0, 1'b1, 16'd0});
    for (int i = 0; i < 3; i++) step(4'b0000);
    step(4'b0000);
    check("vend60_exit", packAct(), {7'd20, 3'd3, 1'b0, 3'b000, 1'b0, 1'b1, 16'd1});
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", packAct(), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    strobeSeen = 3'b000;
    for (int i = 0; i < 8; i++) begin
      step(4'b0000);
      strobeSeen |= {bus.changeQuarter, bus.changeDime, bus.changeNickel};
    end
    check("no_strobe_after_reset", {29'd0, strobeSeen}, 32'd0);
    check("idle_after_reset", packAct(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
